lzss_host_ctrl: RTL and testbench
=================================

# lzss_host_ctrl

Host-side sequencer for the LZSS encoder. It fetches a job of 32-bit input words from a synchronous source memory and feeds them to the encoder under the encoder's `busy` back-pressure. After the last word it raises `drop_done` and waits for `finish`, while counting emitted codewords and compressed bits. It replaces the bench-style host and sits between the system memory/CPU and the `LZSS` encoder.

## Interface
- `ADDR_W`, 10: source memory address width; a job holds 0..2^ADDR_W words.
- `TIMEOUT`, 1024: idle cycles allowed in DRAIN before the watchdog aborts the job.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a job. Ignored unless in IDLE.
- `num_words`  in  ADDR_W+1  job length; sampled on `start`.
- `mem_read`  out  1  read strobe; `mem_data` is valid the following cycle.
- `mem_addr`  out  ADDR_W  word address; runs 0..num_words-1.
- `mem_data`  in  32  read data.
- `enc_data`  out  32  word presented to the encoder.
- `enc_valid`  out  1  one-cycle strobe for `enc_data`.
- `enc_drop_done`  out  1  level; no further words in this job.
- `enc_busy`  in  1  encoder busy.
- `enc_out_valid`  in  1  codeword strobe from the encoder.
- `enc_codeword`  in  11  bit 10 = 1 means match (11 bits); 0 means literal (9 bits).
- `enc_finish`  in  1  encoder has flushed the job.
- `job_busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse at job end.
- `err`  out  1  sticky error; cleared on `start`.
- `words_sent`  out  ADDR_W+1  words delivered so far.
- `code_cnt`  out  12  codewords observed.
- `comp_bits`  out  17  sum of codeword lengths.

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE, on `start`:
  - clear `words_sent`, `code_cnt`, `comp_bits`, `err` and the address counter;
  - go to FEED, or go to DONE directly if `num_words`==0 (no `mem_read`, no `enc_drop_done`).
- FEED uses a one-entry hold register (`hold_full`).
  - Issue `mem_read` when the hold register is empty (or drains this cycle), no read is outstanding, and words remain.
  - Capture `mem_data` into hold on the cycle after `mem_read`.
  - When `hold_full` and `enc_busy`==0 at a clock edge: register `enc_data`<=hold, pulse `enc_valid`, clear `hold_full`, increment `words_sent`.
- Encoder contract: a word strobed by `enc_valid` is accepted even if `enc_busy` rises in that same cycle.
- At most one read is outstanding and at most one word is held. Word order equals address order.
- After the `enc_valid` for word num_words-1, go to DRAIN. `enc_drop_done` rises the next cycle and stays high until DONE.
- DRAIN:
  - `enc_finish` goes to DONE;
  - the watchdog counts cycles without `enc_out_valid`/`enc_finish`; at TIMEOUT it sets `err` and goes to DONE.
- DONE: pulse `done` for one cycle, drop `enc_drop_done`, return to IDLE. Counters hold their values until the next `start`.
- Counting, in any non-IDLE state: on `enc_out_valid`, `code_cnt`+=1 and `comp_bits`+=11 if bit 10 is set, else 9. Counters saturate and do not wrap.
- Error conditions (all set `err`; none change state):
  - `enc_finish` outside DRAIN;
  - `enc_out_valid` in IDLE (the codeword is not counted).

## Timing
- Reset (async assert, sync release): state IDLE. Every output is 0, `mem_addr`=0, `enc_data`=0.
- `start` at edge t: first `mem_read` at t+1; data is held at t+2; the earliest `enc_valid` is at t+3.
- Throughput is at most one word per 2 cycles (read overlaps drain).
- `enc_busy` high: `enc_valid` stays low. Hold keeps its word, and no read is issued beyond the single prefetch.
- `enc_finish` together with `enc_out_valid`: the codeword is counted, then DONE.
- `start` in non-IDLE states: ignored with no side effect.
- `reset_n` low mid-job: immediate abort to the reset values; no `done` pulse.

## Structure
- Package `lzss_pkg`:
  - `CW_W`=11, `CW_MATCH_BIT`=10, `LIT_BITS`=9, `MATCH_BITS`=11;
  - state enum `host_state_t` {IDLE, FEED, DRAIN, DONE}.
- One sub-module, `lzss_fetch_buf`: the read strobe, address counter, outstanding flag and hold register. It exposes `hold_full`, `hold_data` and `pop`. The FSM, counters and watchdog stay in the top level.

## Test plan
- Reset: assert `reset_n`=0 mid-FEED -> all outputs 0, state IDLE, no `done` pulse.
- Basic job: `num_words`=4, `enc_busy`=0, mem[i]=0x61626364+i.
  - Expect `mem_addr` 0,1,2,3 and four `enc_valid` pulses in order.
  - `enc_drop_done` rises 1 cycle after the 4th pulse.
  - Stub emits 3 literals + 2 matches, then `enc_finish` -> `code_cnt`=5, `comp_bits`=49, one `done` pulse, `words_sent`=4.
- Back-pressure: `enc_busy`=1 for 20 cycles after word 0 -> no `enc_valid` during busy, exactly one `mem_read` issued during the stall, words delivered in order afterwards.
- Empty job: `num_words`=0 -> `done` 1 cycle after `start`; no `mem_read`, no `enc_drop_done`, counters 0.
- Watchdog: TIMEOUT=64, stub never asserts `enc_finish` -> `err`=1 and `done` 64 cycles after the last `enc_out_valid`.
- Protocol errors: `start` pulsed mid-job -> ignored. `enc_finish` during FEED -> `err`=1 sticky, feeding continues, `err` cleared by the next `start`.

Source files
------------

// File: rtl/lzss_pkg.sv
// Shared types and constants for the LZSS host-side sequencer.
package lzss_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned CW_W         = 11;
    localparam int unsigned CW_MATCH_BIT = 10;
    localparam int unsigned LIT_BITS     = 9;
    localparam int unsigned MATCH_BITS   = 11;
    localparam int unsigned LEN_W        = 4;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } host_state_t;

    // Compressed length in bits of one encoder codeword.
    function automatic logic [LEN_W-1:0] cw_len(input logic [CW_W-1:0] cw);
        return cw[CW_MATCH_BIT] ? LEN_W'(MATCH_BITS) : LEN_W'(LIT_BITS);
    endfunction

endpackage

// File: rtl/lzss_fetch_buf.sv
// Source-memory fetch path: read strobe, address counter, one outstanding
// read and a one-entry hold register feeding the encoder.
module lzss_fetch_buf
    import lzss_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W:0]   job_len,
    input  logic              feed,
    input  logic              pop,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    output logic              hold_full,
    output logic [WORD_W-1:0] hold_data
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] rd_cnt;
    logic             rd_wait;
    logic             issue;

    // A read is in flight while the strobe is up and for the data cycle after it.
    assign issue = feed && !mem_read && !rd_wait && (!hold_full || pop) && (rd_cnt < len_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q     <= '0;
            rd_cnt    <= '0;
            rd_wait   <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (load) begin
            // The first read goes out on the start edge itself.
            len_q     <= job_len;
            mem_addr  <= '0;
            rd_wait   <= 1'b0;
            hold_full <= 1'b0;
            if (job_len != '0) begin
                mem_read <= 1'b1;
                rd_cnt   <= CNT_W'(1);
            end else begin
                mem_read <= 1'b0;
                rd_cnt   <= '0;
            end
        end else begin
            rd_wait  <= mem_read;
            mem_read <= issue;
            if (issue) begin
                mem_addr <= rd_cnt[ADDR_W-1:0];
                rd_cnt   <= rd_cnt + CNT_W'(1);
            end
            if (rd_wait) begin
                hold_data <= mem_data;
                hold_full <= 1'b1;
            end else if (pop) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lzss_host_ctrl.sv
// Host sequencer for the LZSS encoder: job FSM, encoder handshake,
// codeword/bit counters and drain watchdog.
module lzss_host_ctrl
    import lzss_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    output logic [WORD_W-1:0] enc_data,
    output logic              enc_valid,
    output logic              enc_drop_done,
    input  logic              enc_busy,
    input  logic              enc_out_valid,
    input  logic [CW_W-1:0]   enc_codeword,
    input  logic              enc_finish,
    output logic              job_busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_sent,
    output logic [11:0]       code_cnt,
    output logic [16:0]       comp_bits
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned CODE_W = 12;
    localparam int unsigned BITS_W = 17;
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

    host_state_t       state;
    logic [CNT_W-1:0]  len_q;
    logic [WD_W-1:0]   wd_cnt;
    logic              hold_full;
    logic [WORD_W-1:0] hold_data;
    logic              load;
    logic              pop;
    logic              last_pop;
    logic              wd_expire;
    logic [CODE_W-1:0] code_next;
    logic [BITS_W:0]   bits_sum;
    logic [BITS_W-1:0] bits_next;

    assign load      = (state == IDLE) && start;
    assign pop       = (state == FEED) && hold_full && !enc_busy;
    assign last_pop  = pop && ((words_sent + CNT_W'(1)) == len_q);
    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1)) && !enc_out_valid && !enc_finish;

    // Saturating counter increments.
    assign code_next = (code_cnt == '1) ? code_cnt : code_cnt + CODE_W'(1);
    assign bits_sum  = {1'b0, comp_bits} + (BITS_W + 1)'(cw_len(enc_codeword));
    assign bits_next = bits_sum[BITS_W] ? '1 : bits_sum[BITS_W-1:0];

    lzss_fetch_buf #(
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .job_len   (num_words),
        .feed      (state == FEED),
        .pop       (pop),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .hold_full (hold_full),
        .hold_data (hold_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            len_q         <= '0;
            wd_cnt        <= '0;
            job_busy      <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            enc_drop_done <= 1'b0;
            enc_valid     <= 1'b0;
            enc_data      <= '0;
            words_sent    <= '0;
            code_cnt      <= '0;
            comp_bits     <= '0;
        end else begin
            done      <= 1'b0;
            enc_valid <= 1'b0;

            if ((state != IDLE) && enc_out_valid) begin
                code_cnt  <= code_next;
                comp_bits <= bits_next;
            end

            if (pop) begin
                enc_data   <= hold_data;
                enc_valid  <= 1'b1;
                words_sent <= words_sent + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        words_sent <= '0;
                        code_cnt   <= '0;
                        comp_bits  <= '0;
                        err        <= 1'b0;
                        len_q      <= num_words;
                        wd_cnt     <= '0;
                        job_busy   <= 1'b1;
                        if (num_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FEED;
                        end
                    end
                end
                FEED: begin
                    if (last_pop) begin
                        state  <= DRAIN;
                        wd_cnt <= '0;
                    end
                end
                DRAIN: begin
                    enc_drop_done <= 1'b1;
                    if (enc_out_valid || enc_finish) begin
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                    if (enc_finish || wd_expire) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        enc_drop_done <= 1'b0;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    job_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    job_busy <= 1'b0;
                end
            endcase

            // Error sources win over the clear-on-start above.
            if ((enc_out_valid && (state == IDLE)) ||
                (enc_finish && (state != DRAIN)) ||
                ((state == DRAIN) && wd_expire)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lzss_host_ctrl.sv
// Scoreboard bench for lzss_host_ctrl: memory model, encoder stub, word/address queues.
module tb_lzss_host_ctrl;
    import lzss_pkg::*;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [31:0]       enc_data;
    logic              enc_valid;
    logic              enc_drop_done;
    logic              enc_busy;
    logic              enc_out_valid;
    logic [CW_W-1:0]   enc_codeword;
    logic              enc_finish;
    logic              job_busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_sent;
    logic [11:0]       code_cnt;
    logic [16:0]       comp_bits;

    logic [31:0] mem [64];
    logic [31:0] exp_q[$];
    int          addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n = 0;
    int n_rd = 0, n_rd_busy = 0, n_val = 0, n_val_busy = 0, n_done = 0;
    int last_val_cyc = 0, drop_rise_cyc = 0;
    logic busy_q = 1'b0;
    logic drop_prev = 1'b0;
    int rd_base, val_base, done_base, last_cv, k;
    int rb, vb;

    lzss_host_ctrl #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .num_words     (num_words),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .enc_data      (enc_data),
        .enc_valid     (enc_valid),
        .enc_drop_done (enc_drop_done),
        .enc_busy      (enc_busy),
        .enc_out_valid (enc_out_valid),
        .enc_codeword  (enc_codeword),
        .enc_finish    (enc_finish),
        .job_busy      (job_busy),
        .done          (done),
        .err           (err),
        .words_sent    (words_sent),
        .code_cnt      (code_cnt),
        .comp_bits     (comp_bits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Synchronous source memory: data valid the cycle after the strobe.
    always @(posedge clk) begin
        cyc_n  <= cyc_n + 1;
        busy_q <= enc_busy;
        if (mem_read) mem_data <= mem[mem_addr];
    end

    // Output monitor: addresses and words are compared against the queues.
    always @(negedge clk) begin
        if (mem_read) begin
            n_rd <= n_rd + 1;
            if (enc_busy) n_rd_busy <= n_rd_busy + 1;
            if (addr_q.size() == 0) check("mem_read_extra", 32'(1), 32'(0));
            else check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
        end
        if (enc_valid) begin
            n_val        <= n_val + 1;
            last_val_cyc <= cyc_n;
            if (busy_q) n_val_busy <= n_val_busy + 1;
            if (exp_q.size() == 0) check("enc_valid_extra", 32'(1), 32'(0));
            else check("enc_word", enc_data, exp_q.pop_front());
        end
        if (enc_drop_done && !drop_prev) drop_rise_cyc <= cyc_n;
        drop_prev <= enc_drop_done;
        if (done) n_done <= n_done + 1;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[i]);
            addr_q.push_back(i);
        end
        rd_base   = n_rd;
        val_base  = n_val;
        done_base = n_done;
        num_words = (ADDR_W + 1)'(n);
        start     = 1'b1;
        cyc(1);
        start     = 1'b0;
    endtask

    task automatic wait_drop(input int limit);
        int w = 0;
        while (!enc_drop_done && w < limit) begin
            cyc(1);
            w++;
        end
        if (!enc_drop_done) check("drop_timeout", 32'(0), 32'(1));
    endtask

    task automatic emit(input logic [CW_W-1:0] cw);
        enc_out_valid = 1'b1;
        enc_codeword  = cw;
        cyc(1);
        enc_out_valid = 1'b0;
    endtask

    task automatic finish_pulse();
        enc_finish = 1'b1;
        cyc(1);
        enc_finish = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; num_words = '0; enc_busy = 1'b0;
        enc_out_valid = 1'b0; enc_codeword = '0; enc_finish = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h6162_6364 + 32'(i);
        cyc(3);
        check("rst_ctrl", 32'({mem_read, enc_valid, enc_drop_done, job_busy, done, err}), 32'(0));
        check("rst_addr_data", 32'(mem_addr) | enc_data, 32'(0));
        check("rst_counters", 32'(words_sent) | 32'(code_cnt) | 32'(comp_bits), 32'(0));
        reset_n = 1'b1;
        cyc(2);

        // Basic 4-word job
        start_job(4);
        check("first_read", 32'(mem_read), 32'(1));
        check("job_busy_on", 32'(job_busy), 32'(1));
        cyc(2);
        check("no_early_valid", 32'(enc_valid), 32'(0));
        cyc(1);
        check("first_valid", 32'(enc_valid), 32'(1));
        wait_drop(100);
        emit(11'h061); emit(11'h062); emit(11'h0FF); emit(11'h455); emit(11'h7FF);
        check("drop_lag", 32'(drop_rise_cyc - last_val_cyc), 32'(1));
        check("drop_level", 32'(enc_drop_done), 32'(1));
        finish_pulse();
        check("done_pulse", 32'(done), 32'(1));
        cyc(1);
        check("done_one_cycle", 32'({done, enc_drop_done}), 32'(0));
        cyc(2);
        check("basic_code_cnt", 32'(code_cnt), 32'(5));
        check("basic_comp_bits", 32'(comp_bits), 32'(49));
        check("basic_words_sent", 32'(words_sent), 32'(4));
        check("basic_reads", 32'(n_rd - rd_base), 32'(4));
        check("basic_valids", 32'(n_val - val_base), 32'(4));
        check("basic_done_cnt", 32'(n_done - done_base), 32'(1));
        check("basic_idle", 32'({job_busy, err}), 32'(0));

        // Back-pressure after word 0
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        start_job(5);
        k = 0;
        while (!enc_valid && k < 20) begin
            cyc(1);
            k++;
        end
        if (!enc_valid) check("bp_first_timeout", 32'(0), 32'(1));
        enc_busy = 1'b1;
        rb = n_rd_busy;
        vb = n_val_busy;
        cyc(20);
        check("bp_held_one_word", 32'(n_val - val_base), 32'(1));
        enc_busy = 1'b0;
        wait_drop(100);
        check("bp_stall_reads", 32'(n_rd_busy - rb), 32'(1));
        check("bp_stall_valids", 32'(n_val_busy - vb), 32'(0));
        emit(11'h001);
        finish_pulse();
        cyc(3);
        check("bp_words_sent", 32'(words_sent), 32'(5));
        check("bp_valids", 32'(n_val - val_base), 32'(5));
        check("bp_reads", 32'(n_rd - rd_base), 32'(5));
        check("bp_counts", 32'({code_cnt, comp_bits}), 32'({12'd1, 17'd9}));

        // Empty job
        start_job(0);
        check("empty_done", 32'(done), 32'(1));
        check("empty_no_rd", 32'({mem_read, enc_drop_done}), 32'(0));
        cyc(1);
        check("empty_back_idle", 32'({done, job_busy}), 32'(0));
        check("empty_counters", 32'(words_sent) | 32'(code_cnt) | 32'(comp_bits), 32'(0));
        cyc(2);
        check("empty_reads", 32'(n_rd - rd_base), 32'(0));
        check("empty_done_cnt", 32'(n_done - done_base), 32'(1));

        // Codeword while idle: error, not counted
        emit(11'h003);
        cyc(1);
        check("idle_cw_err", 32'(err), 32'(1));
        check("idle_cw_not_counted", 32'(code_cnt), 32'(0));

        // Watchdog
        start_job(2);
        check("wd_err_cleared", 32'(err), 32'(0));
        wait_drop(100);
        emit(11'h400);
        last_cv = cyc_n;
        k = 0;
        while (!err && k < 200) begin
            cyc(1);
            k++;
        end
        check("wd_latency", 32'(cyc_n - last_cv), 32'(TIMEOUT));
        check("wd_done", 32'(done), 32'(1));
        check("wd_counts", 32'({code_cnt, comp_bits}), 32'({12'd1, 17'd11}));
        cyc(1);
        check("wd_idle", 32'({job_busy, enc_drop_done}), 32'(0));

        // Protocol errors: stray start and early finish
        start_job(6);
        check("proto_err_cleared", 32'(err), 32'(0));
        cyc(2);
        num_words = (ADDR_W + 1)'(3);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        enc_finish = 1'b1;
        cyc(1);
        enc_finish = 1'b0;
        check("finish_in_feed_err", 32'({err, job_busy}), 32'(3));
        wait_drop(100);
        check("err_sticky_drain", 32'(err), 32'(1));
        finish_pulse();
        cyc(3);
        check("proto_words_sent", 32'(words_sent), 32'(6));
        check("proto_valids", 32'(n_val - val_base), 32'(6));
        check("proto_reads", 32'(n_rd - rd_base), 32'(6));
        check("proto_done_cnt", 32'(n_done - done_base), 32'(1));
        check("err_sticky_idle", 32'(err), 32'(1));
        start_job(1);
        check("err_cleared_by_start", 32'(err), 32'(0));
        wait_drop(100);
        finish_pulse();
        cyc(3);
        check("single_valids", 32'(n_val - val_base), 32'(1));

        // Reset in the middle of a feed
        start_job(8);
        cyc(5);
        reset_n = 1'b0;
        #1;
        check("midrst_ctrl", 32'({mem_read, enc_valid, enc_drop_done, job_busy, done, err}), 32'(0));
        check("midrst_data", 32'(mem_addr) | enc_data | 32'(words_sent), 32'(0));
        exp_q.delete();
        addr_q.delete();
        cyc(3);
        check("midrst_no_done", 32'(n_done - done_base), 32'(0));
        reset_n = 1'b1;
        cyc(2);
        check("midrst_idle", 32'({job_busy, mem_read}), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
